// File: rtl/pe_pkg.sv
// pe_pkg: shared state encoding and default sizing for the responder and its controller.
package pe_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACT, RUN, DONE, COOL} pe_state_t;
   localparam int PE_DATA_W = 8;
   localparam int PE_DEPTH  = 4;
endpackage

// File: rtl/pe_buffer.sv
// pe_buffer: DEPTH x DATA_W register file, one write port, one combinational read port.
module pe_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pe_responder.sv
// pe_responder: fetches DEPTH words on rd, sums them on act, pulses done, then waits
// for rd and act to both fall before accepting another job.
module pe_responder
   import pe_pkg::*;
#(
   parameter int DATA_W = PE_DATA_W,
   parameter int DEPTH  = PE_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int RES_W  = DATA_W + $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd,
   input  logic              act,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [RES_W-1:0]  result,
   output logic              done
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   pe_state_t         state_q, state_d;
   logic              mem_re_q, mem_re_d, vld_q, done_q, we;
   logic [ADDR_W-1:0] addr_q, addr_d, cap_q, cap_d, run_q, run_d;
   logic [RES_W-1:0]  acc_q, acc_d, result_q, result_d, sum;
   logic [DATA_W-1:0] rdata;

   pe_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (cap_q),
      .wdata_i (mem_data),
      .raddr_i (run_q),
      .rdata_o (rdata)
   );

   assign sum = acc_q + {{(RES_W-DATA_W){1'b0}}, rdata};

   always_comb begin
      state_d  = state_q;
      mem_re_d = mem_re_q;
      addr_d   = addr_q;
      cap_d    = cap_q;
      run_d    = run_q;
      acc_d    = acc_q;
      result_d = result_q;
      we       = 1'b0;
      unique case (state_q)
         IDLE: if (rd) begin
            state_d  = LOAD;
            mem_re_d = 1'b1;
            addr_d   = '0;
            cap_d    = '0;
         end
         LOAD: if (!rd) begin
            // abort beats a coincident last capture; later read data is ignored in IDLE
            state_d  = IDLE;
            mem_re_d = 1'b0;
         end else begin
            if (mem_re_q) begin
               mem_re_d = addr_q != LAST;
               addr_d   = addr_q == LAST ? addr_q : addr_q + 1'b1;
            end
            if (vld_q) begin
               we    = 1'b1;
               cap_d = cap_q + 1'b1;
               if (cap_q == LAST) begin
                  state_d = act ? RUN : WAIT_ACT;
                  acc_d   = '0;
                  run_d   = '0;
               end
            end
         end
         WAIT_ACT: if (!rd) state_d = IDLE;
         else if (act) begin
            state_d = RUN;
            acc_d   = '0;
            run_d   = '0;
         end
         RUN: if (!act) state_d = IDLE;
         else begin
            acc_d = sum;
            run_d = run_q + 1'b1;
            if (run_q == LAST) begin
               result_d = sum;
               state_d  = DONE;
            end
         end
         DONE: state_d = COOL;
         COOL: if (!rd && !act) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         mem_re_q <= 1'b0;
         addr_q   <= '0;
         vld_q    <= 1'b0;
         cap_q    <= '0;
         run_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_re_q <= mem_re_d;
         addr_q   <= addr_d;
         vld_q    <= mem_re_q;
         cap_q    <= cap_d;
         run_q    <= run_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         done_q   <= state_d == DONE;
      end

   assign mem_re   = mem_re_q;
   assign mem_addr = addr_q;
   assign result   = result_q;
   assign done     = done_q;
endmodule

// File: tb/tb_pe_responder.sv
// tb_pe_responder: directed jobs against a synchronous-read memory model.
module tb_pe_responder;
   logic       clk = 1'b0, rst_n = 1'b0, rd = 1'b0, act = 1'b0;
   logic       mem_re, done;
   logic [1:0] mem_addr;
   logic [7:0] mem_data = '0;
   logic [9:0] result;
   logic [7:0] mem [4];
   int         n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_re) mem_data <= mem[mem_addr];

   pe_responder dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd       (rd),
      .act      (act),
      .mem_re   (mem_re),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .result   (result),
      .done     (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_mem(input logic [7:0] a, b, c, d);
      mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
   endtask

   // act_edge: first edge at which act is sampled high (0 = with rd)
   task automatic job(input string tag, input int act_edge, input int exp_res, input int exp_edge);
      int done_edge = -1;
      rd  = 1'b1;
      act = act_edge == 0;
      for (int e = 0; e < 40 && done_edge < 0; e++) begin
         tick;
         if (e < 4) begin
            check({tag, " addr"}, mem_addr, e);
            check({tag, " re"}, mem_re, 1);
         end
         if (e == 4) check({tag, " re_off"}, mem_re, 0);
         if (e + 1 == act_edge) act = 1'b1;
         if (done) done_edge = e;
      end
      check({tag, " done_edge"}, done_edge, exp_edge);
      check({tag, " result"}, result, exp_res);
      tick;
      check({tag, " pulse"}, done, 0);
   endtask

   task automatic release_ctl;
      rd  = 1'b0;
      act = 1'b0;
      tick;
      tick;
   endtask

   initial begin
      int dones;
      tick;
      tick;
      check("rst result", result, 0);
      check("rst done", done, 0);
      check("rst re", mem_re, 0);
      check("rst addr", mem_addr, 0);
      rst_n = 1'b1;
      tick;

      load_mem(1, 2, 3, 4);
      job("basic", 2, 10, 9);
      release_ctl;

      load_mem(255, 255, 255, 255);
      job("max", 0, 1020, 9);
      release_ctl;

      load_mem(1, 2, 3, 4);
      job("late", 10, 10, 14);
      release_ctl;

      load_mem(9, 9, 9, 9);
      rd = 1'b1;
      act = 1'b1;
      tick;
      tick;
      tick;
      rd = 1'b0;
      tick;
      check("abort re", mem_re, 0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         tick;
         dones += int'(done);
      end
      check("abort dones", dones, 0);
      check("abort result", result, 10);
      act = 1'b0;
      tick;
      load_mem(5, 6, 7, 8);
      job("fresh", 1, 26, 9);

      dones = 0;
      for (int i = 0; i < 3; i++) begin
         tick;
         dones += int'(done);
         check("hold re", mem_re, 0);
      end
      check("hold dones", dones, 0);
      rd  = 1'b0;
      act = 1'b0;
      tick;
      job("after_cool", 0, 26, 9);
      release_ctl;

      load_mem(10, 20, 30, 40);
      rd  = 1'b1;
      act = 1'b1;
      for (int i = 0; i < 8; i++) tick;
      #2 rst_n = 1'b0;
      #1;
      check("arst result", result, 0);
      check("arst done", done, 0);
      check("arst re", mem_re, 0);
      check("arst addr", mem_addr, 0);
      rd  = 1'b0;
      act = 1'b0;
      #2 rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         dones += int'(done);
      end
      check("arst dones", dones, 0);
      job("post_rst", 0, 100, 9);
      release_ctl;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
